imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
- Owns the single instruction memory (8-bit address, 16-bit word) of the 16-bit pipelined CPU.
- Shares it between two requesters: a host program loader (write side, boot time) and the CPU fetch port (read side, run time).
- Sequences the boot, run and halt phases, and holds the CPU off until a program is loaded and started.
- Sits between the CPU fetch stage and instr_mem storage; detects HALT fetches and out-of-range fetches.

Parameters:
- ADDR_W, 8, instruction address width (memory depth 2^ADDR_W)
- DATA_W, 16, instruction word width
- HALT_OP, 5'b00001, opcode field [15:11] that marks HALT
- HALT_WORD, 16'h0800, word substituted for fetches beyond the loaded program

Ports:
- mem_clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- ld_valid  in  1  loader offers a word
- ld_data  in  16  program word to write
- ld_last  in  1  qualifies ld_valid; marks the final program word
- ld_ready  out  1  controller accepts a loader word this cycle
- start  in  1  single-cycle pulse; begin or restart execution
- reload  in  1  single-cycle pulse; return to boot and reload
- cpu_req  in  1  CPU fetch valid this cycle
- cpu_addr  in  8  CPU fetch address (PC)
- cpu_rdata  out  16  instruction returned to CPU
- cpu_enable  out  1  CPU may advance its pipeline
- cpu_restart  out  1  one-cycle pulse; CPU clears PC to 0
- mem_addr  out  8  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data (combinational read)
- prog_len  out  9  number of words loaded (0..256)
- halted  out  1  HALT fetched; CPU frozen
- load_err  out  1  loader overflowed the 256-word memory
- range_err  out  1  sticky; CPU fetched at or beyond prog_len

Behaviour:
- States: BOOT, WAIT, RUN, HALT. Reset → BOOT.
- Reset values: wr_ptr=0, prog_len=0, cpu_enable=0, cpu_restart=0, halted=0, load_err=0, range_err=0, mem_we=0.
  - ld_ready=1 immediately after reset deassertion, because it is decoded from BOOT.
- Memory mux, combinational from state:
  - BOOT: mem_addr=wr_ptr, mem_wdata=ld_data, mem_we=ld_valid&ld_ready.
  - Other states: mem_addr=cpu_addr, mem_we=0.
- BOOT:
  - ld_ready=1.
  - Each accepted word is written at wr_ptr; then wr_ptr and prog_len increment.
  - Accepted with ld_last=1 → WAIT next cycle.
  - Accepted at wr_ptr=255 with ld_last=0: the write still occurs, prog_len=256, load_err set, → WAIT. wr_ptr wraps to 0 and no further words are accepted.
  - ld_valid=0 → hold; no write.
- WAIT:
  - ld_ready=0, cpu_enable=0.
  - start=1 → RUN, with cpu_restart=1 for exactly the first RUN cycle.
  - start with prog_len=0 (loader never sent a word) is ignored.
- RUN:
  - cpu_enable=1.
  - cpu_rdata=mem_rdata, zero latency, when cpu_addr<prog_len.
  - Otherwise cpu_rdata=HALT_WORD, and range_err is set when cpu_req=1.
  - cpu_req=1 and the delivered word[15:11]==HALT_OP → HALT next cycle. The HALT word itself is still delivered that cycle.
- HALT:
  - halted=1, cpu_enable=0, cpu_rdata=HALT_WORD.
  - start → RUN with cpu_restart pulse; halted clears.
- reload (any state except BOOT):
  - → BOOT; wr_ptr=0, prog_len=0; load_err, range_err and halted clear.
  - reload and start in the same cycle: reload wins.
- Reset mid-load or mid-run: immediate return to BOOT. Memory contents are not cleared.
- cpu_rdata is don't-care in BOOT and WAIT; drive HALT_WORD.

Test Plan:
- Load 19 words, last = 16'h0800 with ld_last → prog_len=19, WAIT. Pulse start → cpu_restart high 1 cycle, cpu_enable=1. Fetch at addr 0 returns the first loaded word (e.g. 16'h4c04).
- RUN, fetch addr 18 with cpu_req=1 returning 16'h0800 → halted=1 and cpu_enable=0 next cycle. Pulse start → RUN, cpu_restart pulse, halted=0.
- RUN, prog_len=19, fetch addr 40 with cpu_req=1 → cpu_rdata=16'h0800, range_err=1 sticky. Opcode is HALT, so → HALT.
- Send 256 words with ld_last never asserted → prog_len=256, load_err=1, WAIT, ld_ready=0. A 257th ld_valid causes no write.
- In HALT, assert start and reload in the same cycle → BOOT, prog_len=0, flags cleared, ld_ready=1.
- Assert reset low mid-load after 5 words → all outputs at reset values asynchronously. After release, ld_ready=1 and the next word writes addr 0.

Source files
------------

// File: rtl/imem_ctrl_if.sv
// Bus bundle between imem_ctrl and its three neighbours: program loader,
// CPU fetch stage and instruction memory storage.
interface imem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  // Loader handshake: a word moves on a rising edge where ld_valid && ld_ready;
  // ld_data/ld_last are only meaningful while ld_valid is high, and ld_ready
  // never depends on ld_valid.
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_enable;
  logic              cpu_restart;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ld_valid, ld_data, ld_last, cpu_req, cpu_addr, mem_rdata,
    output ld_ready, cpu_rdata, cpu_enable, cpu_restart,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output ld_valid, ld_data, ld_last, cpu_req, cpu_addr, mem_rdata,
    input  ld_ready, cpu_rdata, cpu_enable, cpu_restart,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_ctrl.sv
// Instruction memory owner: boot-time program load, run-time fetch with
// HALT / out-of-range detection, and boot/wait/run/halt sequencing.
module imem_ctrl #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 16,
  parameter logic [4:0]        HALT_OP   = 5'b00001,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'h0800
) (
  input  logic            mem_clk,
  input  logic            reset,
  input  logic            start,
  input  logic            reload,
  imem_ctrl_if.slave      bus,
  output logic [ADDR_W:0] prog_len,
  output logic            halted,
  output logic            load_err,
  output logic            range_err,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {S_BOOT, S_WAIT, S_RUN, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W:0]   prog_len_nxt;
  logic              load_err_nxt, range_err_nxt;
  logic              restart_q, restart_nxt;
  logic              accept, in_range, halt_hit;
  logic [DATA_W-1:0] fetch_word;

  assign in_range = {1'b0, bus.cpu_addr} < prog_len;
  assign accept   = bus.ld_valid & bus.ld_ready;

  // Memory port belongs to the loader in BOOT and to the fetch stage otherwise.
  assign bus.ld_ready  = (state == S_BOOT);
  assign bus.mem_addr  = (state == S_BOOT) ? wr_ptr : bus.cpu_addr;
  assign bus.mem_we    = accept;
  assign bus.mem_wdata = bus.ld_data;

  assign fetch_word      = (state == S_RUN && in_range) ? bus.mem_rdata : HALT_WORD;
  assign halt_hit        = (state == S_RUN) && bus.cpu_req &&
                           (fetch_word[DATA_W-1 -: 5] == HALT_OP);
  assign bus.cpu_rdata   = fetch_word;
  assign bus.cpu_enable  = (state == S_RUN);
  assign bus.cpu_restart = restart_q;
  assign halted          = (state == S_HALT);
  assign state_dbg       = state;

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      state     <= S_BOOT;
      wr_ptr    <= '0;
      prog_len  <= '0;
      load_err  <= 1'b0;
      range_err <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      prog_len  <= prog_len_nxt;
      load_err  <= load_err_nxt;
      range_err <= range_err_nxt;
      restart_q <= restart_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    prog_len_nxt  = prog_len;
    load_err_nxt  = load_err;
    range_err_nxt = range_err;
    restart_nxt   = 1'b0;
    case (state)
      S_BOOT: begin
        if (accept) begin
          wr_ptr_nxt   = wr_ptr + ADDR_W'(1);
          prog_len_nxt = prog_len + (ADDR_W+1)'(1);
          if (bus.ld_last) begin
            state_nxt = S_WAIT;
          end else if (wr_ptr == '1) begin
            // Memory full without a final marker: keep what we have, flag it.
            load_err_nxt = 1'b1;
            state_nxt    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (start && prog_len != '0) begin
          state_nxt   = S_RUN;
          restart_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.cpu_req && !in_range) range_err_nxt = 1'b1;
        if (halt_hit) state_nxt = S_HALT;
      end
      S_HALT: begin
        if (start) begin
          state_nxt   = S_RUN;
          restart_nxt = 1'b1;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
    if (reload && state != S_BOOT) begin
      state_nxt     = S_BOOT;
      wr_ptr_nxt    = '0;
      prog_len_nxt  = '0;
      load_err_nxt  = 1'b0;
      range_err_nxt = 1'b0;
      restart_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a behavioural instruction memory attached.
module tb_imem_ctrl;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // clock / reset
  logic mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;
  logic reset;

  logic       start, reload;
  logic [8:0] prog_len;
  logic       halted, load_err, range_err;
  logic [1:0] state_dbg;

  imem_ctrl_if bus ();

  imem_ctrl dut (
    .mem_clk   (mem_clk),
    .reset     (reset),
    .start     (start),
    .reload    (reload),
    .bus       (bus),
    .prog_len  (prog_len),
    .halted    (halted),
    .load_err  (load_err),
    .range_err (range_err),
    .state_dbg (state_dbg)
  );

  logic [15:0] mem [256];
  always @(posedge mem_clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  // scoreboard
  logic [15:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic load_word(input logic [15:0] d, input logic last, input logic [7:0] addr);
    @(negedge mem_clk);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    #1;
    check("ld_we", 32'(bus.mem_we), 32'd1);
    check("ld_addr", 32'(bus.mem_addr), 32'(addr));
    @(posedge mem_clk);
    #1;
  endtask

  task automatic loader_idle();
    @(negedge mem_clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic pulse_start_begin();
    @(negedge mem_clk);
    start = 1'b1;
    @(posedge mem_clk);
    #1;
  endtask

  task automatic drop_start();
    @(negedge mem_clk);
    start = 1'b0;
  endtask

  task automatic fetch(input logic req, input logic [7:0] addr);
    @(negedge mem_clk);
    bus.cpu_req  = req;
    bus.cpu_addr = addr;
    #1;
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b0;
    start = 1'b0;
    reload = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;

    #12;
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_cpu_enable", 32'(bus.cpu_enable), 32'd0);
    check("rst_cpu_restart", 32'(bus.cpu_restart), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_BOOT));
    @(negedge mem_clk);
    reset = 1'b1;

    // 19-word program ending in HALT
    for (int i = 0; i < 19; i++) begin
      w = (i == 0) ? 16'h4c04 : (i == 18) ? 16'h0800 : 16'h1000 + 16'(i);
      exp_q.push_back(w);
      load_word(w, i == 18, 8'(i));
    end
    loader_idle();
    #1;
    check("load19_prog_len", 32'(prog_len), 32'd19);
    check("load19_state", 32'(state_dbg), 32'(ST_WAIT));
    check("load19_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("load19_cpu_enable", 32'(bus.cpu_enable), 32'd0);
    check("load19_mem0", 32'(mem[0]), 32'h4c04);
    check("load19_mem18", 32'(mem[18]), 32'h0800);

    pulse_start_begin();
    check("start_restart", 32'(bus.cpu_restart), 32'd1);
    check("start_enable", 32'(bus.cpu_enable), 32'd1);
    check("start_state", 32'(state_dbg), 32'(ST_RUN));
    drop_start();
    tick();
    check("restart_one_cycle", 32'(bus.cpu_restart), 32'd0);

    for (int a = 0; a < 18; a++) begin
      fetch(1'b1, 8'(a));
      w = exp_q.pop_front();
      check("fetch_word", 32'(bus.cpu_rdata), 32'(w));
    end
    fetch(1'b1, 8'd18);
    w = exp_q.pop_front();
    check("fetch_halt_word", 32'(bus.cpu_rdata), 32'(w));
    check("fetch_no_range_err", 32'(range_err), 32'd0);
    tick();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_enable", 32'(bus.cpu_enable), 32'd0);
    check("halt_rdata", 32'(bus.cpu_rdata), 32'h0800);
    check("halt_state", 32'(state_dbg), 32'(ST_HALT));
    fetch(1'b0, 8'd0);

    pulse_start_begin();
    check("rerun_restart", 32'(bus.cpu_restart), 32'd1);
    check("rerun_halted", 32'(halted), 32'd0);
    check("rerun_state", 32'(state_dbg), 32'(ST_RUN));
    drop_start();

    // out of range without a request: substituted word, no flag, no halt
    fetch(1'b0, 8'd40);
    check("oor_noreq_rdata", 32'(bus.cpu_rdata), 32'h0800);
    tick();
    check("oor_noreq_range_err", 32'(range_err), 32'd0);
    check("oor_noreq_state", 32'(state_dbg), 32'(ST_RUN));

    fetch(1'b1, 8'd40);
    check("oor_rdata", 32'(bus.cpu_rdata), 32'h0800);
    tick();
    check("oor_range_err", 32'(range_err), 32'd1);
    check("oor_state", 32'(state_dbg), 32'(ST_HALT));
    fetch(1'b0, 8'd0);

    pulse_start_begin();
    check("range_err_sticky", 32'(range_err), 32'd1);
    drop_start();
    fetch(1'b1, 8'd18);
    tick();
    check("halt_again_state", 32'(state_dbg), 32'(ST_HALT));
    fetch(1'b0, 8'd0);

    // start and reload together from HALT: reload wins
    @(negedge mem_clk);
    start = 1'b1;
    reload = 1'b1;
    tick();
    check("reload_state", 32'(state_dbg), 32'(ST_BOOT));
    check("reload_prog_len", 32'(prog_len), 32'd0);
    check("reload_halted", 32'(halted), 32'd0);
    check("reload_range_err", 32'(range_err), 32'd0);
    check("reload_restart", 32'(bus.cpu_restart), 32'd0);
    check("reload_ld_ready", 32'(bus.ld_ready), 32'd1);
    @(negedge mem_clk);
    start = 1'b0;
    reload = 1'b0;

    // overflow: 256 words, never ld_last
    for (int i = 0; i < 256; i++) load_word(16'h2000 + 16'(i), 1'b0, 8'(i));
    check("ovf_prog_len", 32'(prog_len), 32'd256);
    check("ovf_load_err", 32'(load_err), 32'd1);
    check("ovf_state", 32'(state_dbg), 32'(ST_WAIT));
    check("ovf_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("ovf_mem255", 32'(mem[255]), 32'h20ff);
    @(negedge mem_clk);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'hdead;
    #1;
    check("ovf_extra_we", 32'(bus.mem_we), 32'd0);
    tick();
    check("ovf_mem0_kept", 32'(mem[0]), 32'h2000);
    check("ovf_prog_len_kept", 32'(prog_len), 32'd256);
    loader_idle();

    reload = 1'b1;
    tick();
    check("wait_reload_state", 32'(state_dbg), 32'(ST_BOOT));
    check("wait_reload_load_err", 32'(load_err), 32'd0);
    @(negedge mem_clk);
    reload = 1'b0;

    // asynchronous reset in the middle of a load
    for (int i = 0; i < 5; i++) load_word(16'h3000 + 16'(i), 1'b0, 8'(i));
    check("midload_prog_len", 32'(prog_len), 32'd5);
    loader_idle();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_prog_len", 32'(prog_len), 32'd0);
    check("async_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("async_rst_mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge mem_clk);
    reset = 1'b1;
    load_word(16'habcd, 1'b1, 8'd0);
    check("post_rst_mem0", 32'(mem[0]), 32'habcd);
    check("post_rst_prog_len", 32'(prog_len), 32'd1);
    check("post_rst_state", 32'(state_dbg), 32'(ST_WAIT));
    loader_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
